axi_traffic_gen: RTL and testbench

//  Parametrised AXI4 traffic master for DDR2 controller simulation. On start it issues NUM_BURSTS

---
 rtl/axi_tg_pkg.sv | 33 +++
 rtl/axi_tg_pattern.sv | 18 +
 rtl/axi_traffic_gen.sv | 185 ++++++++++++++++++
 tb/tb_axi_traffic_gen.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_tg_pkg.sv
// Shared types and constants for the AXI4 traffic generator (axi_traffic_gen).
package axi_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } tg_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int              ERR_W   = 16;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // per-beat read check result, one bit per error class
  typedef struct packed {
    logic resp_err;
    logic data_err;
    logic last_err;
  } rd_chk_t;

  function automatic logic [ERR_W-1:0] err_add(input logic [ERR_W-1:0] cnt, input logic [1:0] inc);
    logic [ERR_W:0] sum;
    sum = {1'b0, cnt} + {{(ERR_W-1){1'b0}}, inc};
    return sum[ERR_W] ? ERR_MAX : sum[ERR_W-1:0];
  endfunction

endpackage

// File: rtl/axi_tg_pattern.sv
// Combinational data pattern pat(n,b) = SEED ^ {n,b}, replicated/truncated to DATA_WIDTH.
module axi_tg_pattern #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] SEED       = 32'hA5A5_0000
) (
  input  logic [15:0]           burst,
  input  logic [15:0]           beat,
  output logic [DATA_WIDTH-1:0] pat
);

  logic [31:0] word;
  assign word = SEED ^ {burst, beat};

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    assign pat[i] = word[i % 32];
  end

endmodule

// File: rtl/axi_traffic_gen.sv
// AXI4 write (and optional read-back check) traffic master for the DDR2 controller bench.
// Define AXI_TG_RDCHK_EN to add the read-back pass with per-beat data checking.
module axi_traffic_gen
  import axi_tg_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 27,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    BEATS      = 8,
  parameter int                    NUM_BURSTS = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]           SEED       = 32'hA5A5_0000
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic                      wvalid,
  input  logic                      wready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wlast,
  input  logic                      bvalid,
  output logic                      bready,
  input  logic [1:0]                bresp,
  output logic                      arvalid,
  input  logic                      arready,
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [7:0]                arlen,
  input  logic                      rvalid,
  output logic                      rready,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  output logic [ERR_W-1:0]          err_cnt
);

  localparam logic [7:0]            LEN        = 8'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BEATS * (DATA_WIDTH / 8));
  localparam logic [15:0]           LAST_BURST = 16'(NUM_BURSTS - 1);

  tg_state_e             state, state_nxt;
  logic [7:0]            beat;
  logic [15:0]           burst;
  logic [7:0]            wbeat_sel;
  logic [DATA_WIDTH-1:0] wpat;
  logic                  start_acc, aw_hs, w_hs, b_hs, ar_hs, r_hs, r_end;
  logic                  beat_last, last_burst, b_err;
  rd_chk_t               rchk;
  logic [1:0]            err_inc;

  assign awlen   = LEN;
  assign arlen   = LEN;
  assign awsize  = 3'($clog2(DATA_WIDTH / 8));
  assign awburst = BURST_INCR;
  assign wstrb   = '1;
  assign bready  = 1'b1;
  assign rready  = 1'b1;

  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign beat_last  = (beat == LEN);
  assign wlast      = beat_last;
  assign last_burst = (burst == LAST_BURST);
  assign start_acc  = (state == ST_IDLE) && start;
  assign aw_hs      = awvalid && awready;
  assign w_hs       = wvalid && wready;
  assign b_hs       = (state == ST_B) && bvalid;
  assign b_err      = b_hs && (bresp != RESP_OKAY);

  // wdata is loaded on the handshake with the beat that follows it
  assign wbeat_sel = aw_hs ? 8'd0 : beat + 8'd1;

  axi_tg_pattern #(.DATA_WIDTH(DATA_WIDTH), .SEED(SEED)) u_wpat (
    .burst (burst),
    .beat  ({8'd0, wbeat_sel}),
    .pat   (wpat)
  );

`ifdef AXI_TG_RDCHK_EN
  localparam tg_state_e WR_END = ST_AR;

  logic [DATA_WIDTH-1:0] rpat;

  axi_tg_pattern #(.DATA_WIDTH(DATA_WIDTH), .SEED(SEED)) u_rpat (
    .burst (burst),
    .beat  ({8'd0, beat}),
    .pat   (rpat)
  );

  assign ar_hs = arvalid && arready;
  assign r_hs  = (state == ST_R) && rvalid;
  // a missing rlast on the final beat still closes the burst
  assign r_end = r_hs && (rlast || beat_last);

  assign rchk.resp_err = r_hs && (rresp != RESP_OKAY);
  assign rchk.data_err = r_hs && (rdata != rpat);
  assign rchk.last_err = r_hs && (rlast != beat_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      arvalid <= 1'b0;
      araddr  <= BASE_ADDR;
    end else begin
      arvalid <= (state == ST_AR) && !ar_hs;
      if (start_acc || (b_hs && last_burst)) araddr <= BASE_ADDR;
      else if (r_end && !last_burst)        araddr <= araddr + ADDR_STEP;
    end
  end
`else
  localparam tg_state_e WR_END = ST_DONE;

  assign ar_hs   = 1'b0;
  assign r_hs    = 1'b0;
  assign r_end   = 1'b0;
  assign rchk    = '0;
  assign arvalid = 1'b0;
  assign araddr  = BASE_ADDR;

  logic unused_rd;
  assign unused_rd = ^{arready, rvalid, rdata, rresp, rlast};
`endif

  assign err_inc = 2'(b_err) + 2'(rchk.resp_err) + 2'(rchk.data_err) + 2'(rchk.last_err);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)          state_nxt = ST_AW;
      ST_AW:   if (aw_hs)          state_nxt = ST_W;
      ST_W:    if (w_hs && wlast)  state_nxt = ST_B;
      ST_B:    if (bvalid)         state_nxt = last_burst ? WR_END : ST_AW;
      ST_AR:   if (ar_hs)          state_nxt = ST_R;
      ST_R:    if (r_end)          state_nxt = last_burst ? ST_DONE : ST_AR;
      ST_DONE:                     state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      awaddr  <= BASE_ADDR;
      wdata   <= '0;
      beat    <= '0;
      burst   <= '0;
      err_cnt <= '0;
    end else begin
      state   <= state_nxt;
      // valids rise one cycle after state entry and drop on the accepting handshake
      awvalid <= (state == ST_AW) && !aw_hs;
      wvalid  <= (state == ST_W) && !(w_hs && wlast);

      if (aw_hs || w_hs) wdata <= wpat;

      if (aw_hs || ar_hs)     beat <= '0;
      else if (w_hs || r_hs)  beat <= beat + 8'd1;

      if (start_acc) begin
        burst  <= '0;
        awaddr <= BASE_ADDR;
      end else if (b_hs) begin
        if (last_burst) begin
          burst <= '0;
        end else begin
          burst  <= burst + 16'd1;
          awaddr <= awaddr + ADDR_STEP;
        end
      end else if (r_end && !last_burst) begin
        burst <= burst + 16'd1;
      end

      err_cnt <= start_acc ? '0 : err_add(err_cnt, err_inc);
    end
  end

endmodule

// File: tb/tb_axi_traffic_gen.sv
// Randomized self-checking bench for axi_traffic_gen with a behavioural AXI slave/scoreboard.
module tb_axi_traffic_gen;

  localparam int          AW    = 27;
  localparam int          DW    = 32;
  localparam int          BEATS = 8;
  localparam int          NB    = 4;
  localparam logic [31:0] SEED  = 32'hA5A5_0000;
  localparam logic [AW-1:0] S_BASE = 27'h40;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // main DUT: BEATS=8, NUM_BURSTS=4
  logic start = 1'b0;
  logic busy, done, awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic arvalid, arready, rvalid, rready, rlast;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst, bresp, rresp;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [15:0]   err_cnt;

  axi_traffic_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(BEATS), .NUM_BURSTS(NB),
                    .BASE_ADDR('0), .SEED(SEED)) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .err_cnt(err_cnt)
  );

  // second DUT: BEATS=1, NUM_BURSTS=1, always-ready slave
  logic s_start = 1'b0;
  logic s_busy, s_done, s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready;
  logic s_awready = 1'b1, s_wready = 1'b1, s_arready = 1'b1;
  logic s_bvalid = 1'b0, s_rvalid = 1'b0, s_rlast = 1'b0;
  logic [1:0]    s_bresp = 2'b00, s_rresp = 2'b00;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [7:0]    s_awlen, s_arlen;
  logic [2:0]    s_awsize;
  logic [1:0]    s_awburst;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [3:0]    s_wstrb;
  logic [15:0]   s_err_cnt;

  axi_traffic_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(1), .NUM_BURSTS(1),
                    .BASE_ADDR(S_BASE), .SEED(SEED)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(s_start), .busy(s_busy), .done(s_done),
    .awvalid(s_awvalid), .awready(s_awready), .awaddr(s_awaddr), .awlen(s_awlen),
    .awsize(s_awsize), .awburst(s_awburst),
    .wvalid(s_wvalid), .wready(s_wready), .wdata(s_wdata), .wstrb(s_wstrb), .wlast(s_wlast),
    .bvalid(s_bvalid), .bready(s_bready), .bresp(s_bresp),
    .arvalid(s_arvalid), .arready(s_arready), .araddr(s_araddr), .arlen(s_arlen),
    .rvalid(s_rvalid), .rready(s_rready), .rdata(s_rdata), .rresp(s_rresp), .rlast(s_rlast),
    .err_cnt(s_err_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] pat(input int n, input int b);
    longint v;
    v = longint'(n % 65536) * 65536 + longint'(b % 65536);
    return SEED ^ v[31:0];
  endfunction

  function automatic longint exp_addr(input longint base, input int n);
    return (base + longint'(n) * BEATS * (DW / 8)) % (longint'(1) << AW);
  endfunction

  // slave behaviour / fault injection
  int mode;            // 0 always ready, 1 wready toggles, 2 random
  int bad_rd_n, bad_rd_b, bresp_bad_n, early_n, early_b;
  // scoreboard
  int aw_n, w_n, w_b, w_beats, wlast_cnt, b_n, b_delay, ar_n, r_beats, done_cnt, exp_err;
  int r_q[$];
  bit b_pend, r_active, prev_stall, r_early, r_bad;
  int r_n, r_b;
  logic [DW-1:0] prev_wdata;
  logic prev_wlast;

  initial begin
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = '0; rlast = 1'b0;
  end

  always @(negedge clk) begin
    if (!rstn) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      b_pend = 1'b0; r_active = 1'b0; prev_stall = 1'b0;
      r_q.delete();
    end else begin
      if (done) done_cnt++;

      // R: beats start only once the AR seen on an earlier edge has moved the DUT to R
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      if (!r_active && r_q.size() > 0) begin
        r_n = r_q.pop_front(); r_b = 0; r_active = 1'b1;
      end
      if (r_active && (mode != 2 || $urandom_range(0, 2) != 0)) begin
        r_early = (r_n == early_n) && (r_b == early_b) && (r_b != BEATS - 1);
        r_bad   = (r_n == bad_rd_n) && (r_b == bad_rd_b);
        rvalid  = 1'b1;
        rdata   = pat(r_n, r_b) ^ (r_bad ? 32'd1 : 32'd0);
        rlast   = (r_b == BEATS - 1) || r_early;
        if (r_bad)   exp_err++;
        if (r_early) exp_err++;
        r_beats++;
        if (rlast) r_active = 1'b0;
        else       r_b++;
      end else if (mode == 2 && wvalid && $urandom_range(0, 3) == 0) begin
        rvalid = 1'b1; rresp = 2'b10; rdata = $urandom; rlast = 1'b1;
      end

      arready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (arvalid && arready) begin
        chk("araddr", araddr, exp_addr(0, ar_n));
        chk("arlen", arlen, BEATS - 1);
        r_q.push_back(ar_n);
        ar_n++;
      end

      awready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (awvalid && awready) begin
        chk("awaddr", awaddr, exp_addr(0, aw_n));
        chk("awlen", awlen, BEATS - 1);
        aw_n++;
      end

      case (mode)
        0:       wready = 1'b1;
        1:       wready = ~wready;
        default: wready = 1'($urandom_range(0, 1));
      endcase
      if (prev_stall) begin
        chk("w_hold", wvalid, 1);
        chk("w_stable_data", wdata, prev_wdata);
        chk("w_stable_last", wlast, prev_wlast);
      end
      if (wvalid && wready) begin
        chk("wdata", wdata, pat(w_n, w_b));
        chk("wlast", wlast, (w_b == BEATS - 1));
        if (wlast) wlast_cnt++;
        w_beats++;
        prev_stall = 1'b0;
        if (w_b == BEATS - 1) begin
          w_n++; w_b = 0; b_pend = 1'b1; b_delay = $urandom_range(2, 4);
        end else begin
          w_b++;
        end
      end else begin
        prev_stall = wvalid; prev_wdata = wdata; prev_wlast = wlast;
      end

      bvalid = 1'b0; bresp = 2'b00;
      if (b_pend) begin
        b_delay--;
        if (b_delay == 0) begin
          bvalid = 1'b1;
          bresp  = (b_n == bresp_bad_n) ? 2'b10 : 2'b00;
          if (b_n == bresp_bad_n) exp_err++;
          b_n++;
          b_pend = 1'b0;
        end
      end else if (mode == 2 && wvalid && $urandom_range(0, 3) == 0) begin
        bvalid = 1'b1; bresp = 2'b11;
      end
    end
  end

  // second-DUT slave
  int s_done_cnt, s_aw_cnt, s_w_cnt, s_r_cnt;
  bit s_b_pend, s_r_pend;

  always @(negedge clk) begin
    if (!rstn) begin
      s_bvalid = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_b_pend = 1'b0; s_r_pend = 1'b0;
    end else begin
      if (s_done) s_done_cnt++;
      s_bvalid = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
      if (s_b_pend) begin s_bvalid = 1'b1; s_b_pend = 1'b0; end
      if (s_r_pend) begin
        s_rvalid = 1'b1; s_rdata = pat(0, 0); s_rlast = 1'b1; s_r_pend = 1'b0; s_r_cnt++;
      end
      if (s_awvalid) begin
        chk("s_awaddr", s_awaddr, S_BASE);
        chk("s_awlen", s_awlen, 0);
        s_aw_cnt++;
      end
      if (s_wvalid) begin
        chk("s_wdata", s_wdata, pat(0, 0));
        chk("s_wlast", s_wlast, 1);
        s_w_cnt++;
        s_b_pend = 1'b1;
      end
      if (s_arvalid) begin
        chk("s_araddr", s_araddr, S_BASE);
        s_r_pend = 1'b1;
      end
    end
  end

  task automatic setup(input int m, input int bn, input int bb, input int brn,
                       input int en, input int eb);
    @(posedge clk); #1;
    mode = m; bad_rd_n = bn; bad_rd_b = bb; bresp_bad_n = brn; early_n = en; early_b = eb;
    aw_n = 0; w_n = 0; w_b = 0; w_beats = 0; wlast_cnt = 0; b_n = 0; ar_n = 0;
    r_beats = 0; done_cnt = 0; exp_err = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("awvalid_lag", awvalid, 0);
    chk("err_clr_on_start", err_cnt, 0);
  endtask

  task automatic run_pass(input string name, input int m, input int bn, input int bb,
                          input int brn, input int en, input int eb, input bit mid_start);
    int exp_r;
    setup(m, bn, bb, brn, en, eb);
    pulse_start();
    if (mid_start) begin
      repeat (20) @(negedge clk);
      chk({name, "_busy_mid"}, busy, 1);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    for (int i = 0; i < 5000 && done_cnt == 0; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    chk({name, "_done_cnt"}, done_cnt, 1);
    chk({name, "_busy_end"}, busy, 0);
    chk({name, "_err_cnt"}, err_cnt, exp_err);
    chk({name, "_aw_cnt"}, aw_n, NB);
    chk({name, "_w_beats"}, w_beats, NB * BEATS);
    chk({name, "_wlast_cnt"}, wlast_cnt, NB);
    chk({name, "_b_cnt"}, b_n, NB);
`ifdef AXI_TG_RDCHK_EN
    exp_r = NB * BEATS - ((en >= 0 && en < NB && eb < BEATS - 1) ? (BEATS - 1 - eb) : 0);
    chk({name, "_ar_cnt"}, ar_n, NB);
    chk({name, "_r_beats"}, r_beats, exp_r);
`else
    exp_r = 0;
    chk({name, "_ar_cnt"}, ar_n, 0);
    chk({name, "_r_beats"}, r_beats, exp_r);
`endif
  endtask

  initial begin
    int err_before;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_araddr", araddr, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("awsize", awsize, 2);
    chk("awburst", awburst, 1);
    chk("wstrb", wstrb, 4'hF);
    chk("bready", bready, 1);
    chk("rready", rready, 1);

    // BEATS=1, NUM_BURSTS=1 with a start pulse while busy
    s_done_cnt = 0; s_aw_cnt = 0; s_w_cnt = 0; s_r_cnt = 0;
    @(negedge clk) s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("s_busy_mid", s_busy, 1);
    s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
    repeat (60) @(negedge clk);
    chk("s_done_cnt", s_done_cnt, 1);
    chk("s_aw_cnt", s_aw_cnt, 1);
    chk("s_w_cnt", s_w_cnt, 1);
    chk("s_err", s_err_cnt, 0);
`ifdef AXI_TG_RDCHK_EN
    chk("s_r_cnt", s_r_cnt, 1);
`else
    chk("s_r_cnt", s_r_cnt, 0);
`endif

    run_pass("basic",   0, -1, -1, -1, -1, -1, 1'b0);
    run_pass("wtoggle", 1, -1, -1, -1, -1, -1, 1'b1);
    run_pass("rdcorrupt", 0, 2, 3, -1, -1, -1, 1'b0);
    run_pass("bresp_early", 0, -1, -1, 0, 1, 5, 1'b0);

    // reset in the middle of burst 1's write data phase
    setup(0, -1, -1, 0, -1, -1);
    pulse_start();
    for (int i = 0; i < 2000 && !(aw_n >= 2 && wvalid); i++) @(negedge clk);
    chk("rst_point_reached", (aw_n >= 2 && wvalid), 1);
    err_before = exp_err;
    chk("err_before_rst", err_cnt, err_before);
    rstn = 1'b0;
    #1;
    chk("mid_rst_awvalid", awvalid, 0);
    chk("mid_rst_wvalid", wvalid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_cnt, 0);
    chk("mid_rst_awaddr", awaddr, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    run_pass("after_rst", 0, -1, -1, -1, -1, -1, 1'b0);

    for (int k = 0; k < 3; k++) begin
      run_pass("random", 2, $urandom_range(0, NB - 1), $urandom_range(0, BEATS - 1),
               $urandom_range(0, NB), $urandom_range(0, NB), $urandom_range(0, BEATS - 2),
               1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
